icache_fetcher: RTL and testbench

- Instruction fetch stage for one compute core. It sits between the core's scheduler and the program-memory controller channel.
- When the scheduler enters FETCH, the block looks up current_pc in a small direct-mapped instruction cache. On a hit it returns the instruction immediately; on a miss it refills the line from program memory.
- It reports progress to the scheduler through fetcher_state and exports cumulative cache statistics for the end-of-kernel performance report.

---
 rtl/icache_fetcher_if.sv | 31 +++
 rtl/icache_fetcher.sv | 173 +++++++++++++++++
 tb/tb_icache_fetcher.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/icache_fetcher_if.sv
// ----------------------------------------------------------------------------
// icache_fetcher_if
// Read channel between the instruction fetcher and the program-memory
// controller. The fetcher issues a request with mem_read_valid and
// mem_read_address. The memory answers with mem_read_ready and mem_read_data.
//   master : fetcher side (drives request, receives response)
//   slave  : memory-controller side (receives request, drives response)
// ----------------------------------------------------------------------------
interface icache_fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/icache_fetcher.sv
// ----------------------------------------------------------------------------
// icache_fetcher
// Instruction fetch stage with a direct-mapped, one-instruction-per-line cache.
// A lookup happens on an IDLE cycle while the scheduler is in FETCH.
//   - On a hit, the instruction is returned on the next cycle.
//   - On a miss, the line is refilled through the program-memory read channel.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   core_state          scheduler state (FETCH=001, DECODE=010)
//   current_pc          address to fetch
//   flush               invalidate every cache line
//   mem                 program-memory read channel (master side)
//   fetcher_state       IDLE=000, FETCHING=001, FETCHED=010
//   instruction         fetched instruction, held while in FETCHED
//   cache_*             cumulative statistics, wrapping modulo 2^32
// ----------------------------------------------------------------------------
module icache_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    icache_fetcher_if.master                 mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [31:0]                      cache_hit_count,
    output logic [31:0]                      cache_miss_count,
    output logic [31:0]                      cache_total_requests,
    output logic [31:0]                      cache_memory_wait_cycles
);
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_t;

    state_t                           state_r;
    state_t                           next_state_s;
    logic [CACHE_LINES-1:0]           valid_r;
    logic [TAG_BITS-1:0]              tag_r  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] data_r [CACHE_LINES];

    logic [IDX_BITS-1:0] lookup_idx_s;
    logic [TAG_BITS-1:0] lookup_tag_s;
    logic [IDX_BITS-1:0] refill_idx_s;
    logic [TAG_BITS-1:0] refill_tag_s;
    logic                lookup_s;
    logic                hit_s;
    logic                refill_s;

    // The latched request address selects the refill line.
    // A pc change during the miss therefore cannot redirect the write.
    assign lookup_idx_s = current_pc[IDX_BITS-1:0];
    assign lookup_tag_s = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    assign refill_idx_s = mem.mem_read_address[IDX_BITS-1:0];
    assign refill_tag_s = mem.mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

    assign lookup_s = (state_r == IDLE) && (core_state == CORE_FETCH);
    assign hit_s    = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);
    assign refill_s = (state_r == FETCHING) && mem.mem_read_ready;

    assign fetcher_state = state_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (lookup_s) begin
                    next_state_s = hit_s ? FETCHED : FETCHING;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCHING: begin
                if (mem.mem_read_ready) begin
                    next_state_s = FETCHED;
                end else begin
                    next_state_s = FETCHING;
                end
            end
            FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FETCHED;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Valid bits: flush wins over a same-cycle refill, so that line stays invalid.
    // The lookup has already sampled the pre-flush bits combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {CACHE_LINES{1'b0}};
        end else if (flush) begin
            valid_r <= {CACHE_LINES{1'b0}};
        end else if (refill_s) begin
            valid_r[refill_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (refill_s) begin
            tag_r[refill_idx_s]  <= refill_tag_s;
            data_r[refill_idx_s] <= mem.mem_read_data;
        end
    end

    // Request channel, delivered instruction and statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.mem_read_valid       <= 1'b0;
            mem.mem_read_address     <= {PROGRAM_MEM_ADDR_BITS{1'b0}};
            instruction              <= {PROGRAM_MEM_DATA_BITS{1'b0}};
            cache_hit_count          <= 32'd0;
            cache_miss_count         <= 32'd0;
            cache_total_requests     <= 32'd0;
            cache_memory_wait_cycles <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (lookup_s) begin
                        cache_total_requests <= cache_total_requests + 32'd1;
                        if (hit_s) begin
                            instruction     <= data_r[lookup_idx_s];
                            cache_hit_count <= cache_hit_count + 32'd1;
                        end else begin
                            cache_miss_count     <= cache_miss_count + 32'd1;
                            mem.mem_read_valid   <= 1'b1;
                            mem.mem_read_address <= current_pc;
                        end
                    end
                end
                FETCHING: begin
                    cache_memory_wait_cycles <= cache_memory_wait_cycles + 32'd1;
                    if (mem.mem_read_ready) begin
                        instruction        <= mem.mem_read_data;
                        mem.mem_read_valid <= 1'b0;
                    end
                end
                FETCHED: begin
                    mem.mem_read_valid <= 1'b0;
                end
                default: begin
                    mem.mem_read_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fetcher.sv
// ----------------------------------------------------------------------------
// tb_icache_fetcher
// Directed bench for icache_fetcher. Each fetch pushes its expected
// instruction onto a scoreboard queue. The entry is popped and compared once
// the DUT reports FETCHED. Statistics are tracked by an independent set of
// expected counters.
// ----------------------------------------------------------------------------
module tb_icache_fetcher;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [31:0] cache_hit_count;
    logic [31:0] cache_miss_count;
    logic [31:0] cache_total_requests;
    logic [31:0] cache_memory_wait_cycles;

    icache_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_if ();

    icache_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .CACHE_LINES(16)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .core_state               (core_state),
        .current_pc               (current_pc),
        .flush                    (flush),
        .mem                      (mem_if),
        .fetcher_state            (fetcher_state),
        .instruction              (instruction),
        .cache_hit_count          (cache_hit_count),
        .cache_miss_count         (cache_miss_count),
        .cache_total_requests     (cache_total_requests),
        .cache_memory_wait_cycles (cache_memory_wait_cycles)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_q[$];
    logic [31:0] e_hit, e_miss, e_tot, e_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit"},   cache_hit_count,          e_hit);
        check({tag, "_miss"},  cache_miss_count,         e_miss);
        check({tag, "_total"}, cache_total_requests,     e_tot);
        check({tag, "_wait"},  cache_memory_wait_cycles, e_wait);
        check({tag, "_inv"},   cache_hit_count + cache_miss_count, cache_total_requests);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {29'd0, fetcher_state}, 32'd0);
        check({tag, "_valid"}, {31'd0, mem_if.mem_read_valid}, 32'd0);
        check({tag, "_addr"},  {24'd0, mem_if.mem_read_address}, 32'd0);
        check({tag, "_instr"}, {16'd0, instruction}, 32'd0);
        check_counters(tag);
    endtask

    // One complete fetch: lookup, optional refill, optional hold, return to IDLE.
    task automatic fetch(input string tag, input logic [7:0] pc, input bit miss,
                         input logic [15:0] mdata, input logic [15:0] exp_instr,
                         input int lat, input bit flush_on_ready, input int hold);
        exp_q.push_back(exp_instr);
        core_state = 3'b001;
        current_pc = pc;
        @(negedge clk);
        e_tot++;
        if (miss) begin
            e_miss++;
            check({tag, "_fetching"}, {29'd0, fetcher_state}, 32'd1);
            check({tag, "_req_valid"}, {31'd0, mem_if.mem_read_valid}, 32'd1);
            check({tag, "_req_addr"}, {24'd0, mem_if.mem_read_address}, {24'd0, pc});
            core_state = 3'b000;
            for (int i = 1; i < lat; i++) begin
                @(negedge clk);
                e_wait++;
                check({tag, "_hold_valid"}, {31'd0, mem_if.mem_read_valid}, 32'd1);
                check({tag, "_hold_addr"}, {24'd0, mem_if.mem_read_address}, {24'd0, pc});
            end
            mem_if.mem_read_ready = 1'b1;
            mem_if.mem_read_data  = mdata;
            flush = flush_on_ready;
            @(negedge clk);
            e_wait++;
            mem_if.mem_read_ready = 1'b0;
            mem_if.mem_read_data  = 16'h0000;
            flush = 1'b0;
            check({tag, "_valid_drop"}, {31'd0, mem_if.mem_read_valid}, 32'd0);
        end else begin
            e_hit++;
            check({tag, "_no_req"}, {31'd0, mem_if.mem_read_valid}, 32'd0);
        end
        check({tag, "_fetched"}, {29'd0, fetcher_state}, 32'd2);
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_sb: observed output with empty scoreboard, expected an entry", tag);
        end else begin
            check({tag, "_instr"}, {16'd0, instruction}, {16'd0, exp_q.pop_front()});
        end
        check_counters(tag);
        if (hold > 0) begin
            core_state = 3'b001;
            repeat (hold) @(negedge clk);
            check({tag, "_hold_state"}, {29'd0, fetcher_state}, 32'd2);
            check({tag, "_hold_noreq"}, {31'd0, mem_if.mem_read_valid}, 32'd0);
            check({tag, "_hold_instr"}, {16'd0, instruction}, {16'd0, exp_instr});
            check_counters({tag, "_hold"});
        end
        core_state = 3'b010;
        @(negedge clk);
        check({tag, "_idle"}, {29'd0, fetcher_state}, 32'd0);
        core_state = 3'b000;
    endtask

    initial begin
        reset = 1'b1;
        core_state = 3'b000;
        current_pc = 8'h00;
        flush = 1'b0;
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_read_data  = 16'h0000;
        e_hit = 32'd0; e_miss = 32'd0; e_tot = 32'd0; e_wait = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, warm hit, conflict on index 5
        fetch("cold",      8'h05, 1'b1, 16'h1234, 16'h1234, 3, 1'b0, 0);
        fetch("warm",      8'h05, 1'b0, 16'h0000, 16'h1234, 0, 1'b0, 0);
        fetch("conflict",  8'h15, 1'b1, 16'hBEEF, 16'hBEEF, 2, 1'b0, 0);
        fetch("conflict2", 8'h05, 1'b1, 16'h1234, 16'h1234, 1, 1'b0, 0);
        check("miss_three", cache_miss_count, 32'd3);

        // Flush in IDLE, then flush coinciding with the refill
        fetch("pre_flush", 8'h05, 1'b0, 16'h0000, 16'h1234, 0, 1'b0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch("post_flush",  8'h05, 1'b1, 16'h1234, 16'h1234, 2, 1'b0, 0);
        fetch("flush_ready", 8'h22, 1'b1, 16'hA5A5, 16'hA5A5, 1, 1'b1, 0);
        fetch("flush_again", 8'h22, 1'b1, 16'hA5A6, 16'hA5A6, 2, 1'b0, 0);

        // Reset while a miss is outstanding
        core_state = 3'b001;
        current_pc = 8'h33;
        @(negedge clk);
        check("abort_req", {31'd0, mem_if.mem_read_valid}, 32'd1);
        core_state = 3'b000;
        reset = 1'b1;
        @(negedge clk);
        e_hit = 32'd0; e_miss = 32'd0; e_tot = 32'd0; e_wait = 32'd0;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'hDEAD;
        @(negedge clk);
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_read_data  = 16'h0000;
        check_reset_outputs("late_ready");

        // Same pc misses after reset; then hold in FETCHED with FETCH asserted
        fetch("after_reset", 8'h33, 1'b1, 16'h3333, 16'h3333, 1, 1'b0, 5);
        fetch("hold_hit",    8'h33, 1'b0, 16'h0000, 16'h3333, 0, 1'b0, 0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
